pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
  SCREEN_W, 480, active width in pixels; SCREEN_H, 272, active height; BALL_SIZE, 10, ball edge length
  PADDLE_H, 60, paddle height; PADDLE_W, 10, paddle width; PADDLE_MARGIN, 20, screen edge to paddle gap
  TICK_DIV, 150000, clk_pix cycles per game tick; PADDLE_SPEED, 4, human paddle px/tick; AI_SPEED, 3, AI paddle px/tick
  SPD_MIN, 2, serve ball speed px/tick per axis; SPD_MAX, 6, speed cap; HITS_PER_LEVEL, 4, paddle hits per speed step
  WIN_SCORE, 11, points to win; SERVE_TICKS, 60, ticks ball rests before serve
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk_pix  in  1  pixel clock, sole clock
  rst  in  1  asynchronous, active-high reset
  game_active  in  1  high = run; low = freeze all state and tick counter
  start  in  1  level, sampled on tick; begins match from IDLE or OVER
  ai_left, ai_right  in  1 each  high = side driven by AI, low = by buttons
  btn_l_up, btn_l_down, btn_r_up, btn_r_down  in  1 each  active-low buttons
  ball_x, ball_y, paddle_left_y, paddle_right_y  out  10 each  top-left coordinates
  score_left, score_right  out  7 each  scores
  game_state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
  winner  out  2  0 none, 1 left, 2 right
  point_pulse  out  1  one clk_pix pulse on each point scored

Function
REQ-003 Tick counter SHALL load TICK_DIV-1 on reset, decrement while game_active, assert tick for one cycle at 0, reload; all updates below occur only on tick.
REQ-004 FSM: IDLE -(start)-> SERVE; SERVE -(SERVE_TICKS ticks)-> PLAY; PLAY -(miss, score<WIN_SCORE)-> SERVE; PLAY -(miss, score reaches WIN_SCORE)-> OVER; OVER -(start)-> SERVE with scores cleared.
REQ-005 In SERVE ball SHALL sit at ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2), speed = SPD_MIN, dy positive, dx toward the side that lost last point (right on first serve).
REQ-006 Velocity SHALL be sign bits plus unsigned speed; positions never underflow or exceed screen: y clamps to 0 or SCREEN_H-BALL_SIZE and reflects dy on the same tick.
REQ-007 Paddle hit = AABB overlap of next ball position with paddle while dx points toward it; SHALL set dx away, set dy sign by ball centre vs paddle centre (above = up), clamp x flush to paddle face.
REQ-008 Hit counter SHALL increment per hit; every HITS_PER_LEVEL hits speed +1, saturating at SPD_MAX; counter and speed reset on serve.
REQ-009 Miss: next x < 0 (left) or next x > SCREEN_W-BALL_SIZE (right); opponent score +1, point_pulse, go to SERVE/OVER.
REQ-010 Same-tick paddle hit and miss: hit SHALL win; wall reflect and paddle hit on one tick both apply (independent axes).
REQ-011 Human paddle: btn_up pressed moves up PADDLE_SPEED, else btn_down moves down; both pressed = up; clamp to [0, SCREEN_H-PADDLE_H].
REQ-012 AI paddle: tracks ball centre vs paddle centre at AI_SPEED, dead-band of AI_SPEED px, same clamp; paddles move in SERVE and PLAY, frozen in IDLE/OVER.
REQ-013 winner SHALL be set on entering OVER and cleared on leaving it; start ignored in SERVE and PLAY.

Reset
REQ-014 rst SHALL asynchronously force: IDLE, ball centred, paddles at (SCREEN_H-PADDLE_H)/2, scores 0, winner 0, point_pulse 0, speed SPD_MIN, hit counter 0, serve dx right.
REQ-015 rst mid-match SHALL discard all progress; first tick after release behaves as power-up.

Structure
REQ-016 Package pong_pkg SHALL hold game_state encoding, coordinate width (10), score width (7) and winner encoding.
REQ-017 Paddle movement SHALL be sub-module pong_paddle_ctrl (human/AI mux, clamp), instantiated once per side.

Verification
REQ-018 TICK_DIV=4: reset, start held -> SERVE; after SERVE_TICKS ticks PLAY, ball_x moves +2 per tick, right side.
REQ-019 Ball at y=1 with dy up, speed 2 -> next y=0, dy down; next tick y=2.
REQ-020 Right AI, left idle, ball aimed past left paddle -> score_right 0->1, one-cycle point_pulse, SERVE, serve dx left.
REQ-021 Four consecutive paddle hits -> speed 2->3; after SPD_MAX reached further hits keep 6.
REQ-022 score_left=10, WIN_SCORE=11, right miss -> OVER, winner=1; start -> SERVE, scores 0.
REQ-023 game_active low for 1000 cycles mid-PLAY -> all outputs unchanged; rst pulse mid-PLAY -> IDLE, ball (235,131).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types, widths and small arithmetic helpers for the pong engine.
// Coordinates are unsigned 10-bit on the ports; internal maths uses a signed 12-bit view.
package pong_pkg;

  localparam int COORD_W = 10;
  localparam int SCORE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'd0,
    WIN_LEFT  = 2'd1,
    WIN_RIGHT = 2'd2
  } winner_t;

  typedef logic signed [COORD_W+1:0] scoord_t;

  function automatic scoord_t to_s(input logic [COORD_W-1:0] v);
    return scoord_t'({2'b00, v});
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input scoord_t v, input logic [COORD_W-1:0] hi);
    if (v < scoord_t'(0)) begin
      return {COORD_W{1'b0}};
    end else if (v > to_s(hi)) begin
      return hi;
    end else begin
      return v[COORD_W-1:0];
    end
  endfunction

  // Axis-aligned overlap of a square (edge asz) at (ax,ay) with a bw x bh box at (bx,by).
  function automatic logic aabb_hit(input scoord_t ax, input scoord_t ay, input scoord_t asz,
                                    input scoord_t bx, input scoord_t by,
                                    input scoord_t bw, input scoord_t bh);
    return (ax < bx + bw) && (ax + asz > bx) && (ay < by + bh) && (ay + asz > by);
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: chooses between button control and AI tracking, then clamps to the screen.
// Position only changes on a game tick while movement is enabled.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H     = 272,
  parameter int BALL_SIZE    = 10,
  parameter int PADDLE_H     = 60,
  parameter int PADDLE_SPEED = 4,
  parameter int AI_SPEED     = 3
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               tick,
  input  logic               move_en,
  input  logic               ai,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_y
);

  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(SCREEN_H - PADDLE_H);
  localparam logic [COORD_W-1:0] Y_INIT = COORD_W'((SCREEN_H - PADDLE_H) / 2);
  localparam scoord_t AI_S      = scoord_t'(AI_SPEED);
  localparam scoord_t HUMAN_S   = scoord_t'(PADDLE_SPEED);
  localparam scoord_t HALF_BALL = scoord_t'(BALL_SIZE / 2);
  localparam scoord_t HALF_PAD  = scoord_t'(PADDLE_H / 2);
  localparam scoord_t ZERO_S    = scoord_t'(0);

  logic [COORD_W-1:0] paddle_y_r;
  scoord_t ball_c_s, pad_c_s, step_s, target_s;

  // Step selection: AI holds still inside a dead-band; buttons are active-low, up wins.
  always_comb begin
    ball_c_s = to_s(ball_y) + HALF_BALL;
    pad_c_s  = to_s(paddle_y_r) + HALF_PAD;
    step_s   = ZERO_S;
    if (ai) begin
      if (ball_c_s < pad_c_s - AI_S) begin
        step_s = -AI_S;
      end else if (ball_c_s > pad_c_s + AI_S) begin
        step_s = AI_S;
      end else begin
        step_s = ZERO_S;
      end
    end else if (!btn_up) begin
      step_s = -HUMAN_S;
    end else if (!btn_down) begin
      step_s = HUMAN_S;
    end else begin
      step_s = ZERO_S;
    end
    target_s = to_s(paddle_y_r) + step_s;
  end

  // Paddle position register.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      paddle_y_r <= Y_INIT;
    end else if (tick && move_en) begin
      paddle_y_r <= clamp_coord(target_s, Y_MAX);
    end
  end

  assign paddle_y = paddle_y_r;

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: tick divider, match FSM, ball physics, scoring and two paddle controllers.
// All game state advances only on the divided tick; game_active low freezes everything.
module pong_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W       = 480,
  parameter int SCREEN_H       = 272,
  parameter int BALL_SIZE      = 10,
  parameter int PADDLE_H       = 60,
  parameter int PADDLE_W       = 10,
  parameter int PADDLE_MARGIN  = 20,
  parameter int TICK_DIV       = 150000,
  parameter int PADDLE_SPEED   = 4,
  parameter int AI_SPEED       = 3,
  parameter int SPD_MIN        = 2,
  parameter int SPD_MAX        = 6,
  parameter int HITS_PER_LEVEL = 4,
  parameter int WIN_SCORE      = 11,
  parameter int SERVE_TICKS    = 60
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               game_active,
  input  logic               start,
  input  logic               ai_left,
  input  logic               ai_right,
  input  logic               btn_l_up,
  input  logic               btn_l_down,
  input  logic               btn_r_up,
  input  logic               btn_r_down,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_left_y,
  output logic [COORD_W-1:0] paddle_right_y,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         game_state,
  output logic [1:0]         winner,
  output logic               point_pulse
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);

  localparam logic [COORD_W-1:0] X_CTR     = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_CTR     = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] LP_BALL_X = COORD_W'(PADDLE_MARGIN + PADDLE_W);
  localparam logic [COORD_W-1:0] RP_BALL_X = COORD_W'(SCREEN_W - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);

  localparam scoord_t ZERO_S    = scoord_t'(0);
  localparam scoord_t X_MAX_S   = scoord_t'(SCREEN_W - BALL_SIZE);
  localparam scoord_t Y_MAX_S   = scoord_t'(SCREEN_H - BALL_SIZE);
  localparam scoord_t BALL_S    = scoord_t'(BALL_SIZE);
  localparam scoord_t HALF_BALL = scoord_t'(BALL_SIZE / 2);
  localparam scoord_t PAD_W_S   = scoord_t'(PADDLE_W);
  localparam scoord_t PAD_H_S   = scoord_t'(PADDLE_H);
  localparam scoord_t HALF_PAD  = scoord_t'(PADDLE_H / 2);
  localparam scoord_t LP_X_S    = scoord_t'(PADDLE_MARGIN);
  localparam scoord_t RP_X_S    = scoord_t'(SCREEN_W - PADDLE_MARGIN - PADDLE_W);

  localparam logic [7:0]         SPD_MIN_V  = 8'(SPD_MIN);
  localparam logic [7:0]         SPD_MAX_V  = 8'(SPD_MAX);
  localparam logic [7:0]         HITS_V     = 8'(HITS_PER_LEVEL);
  localparam logic [SCORE_W-1:0] WIN_V      = SCORE_W'(WIN_SCORE);
  localparam logic [15:0]        SERVE_LAST = 16'(SERVE_TICKS - 1);

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;

  game_state_t        state_r, state_s;
  winner_t            winner_r, winner_s;
  logic [COORD_W-1:0] ball_x_r, ball_x_s, ball_y_r, ball_y_s;
  logic               dx_left_r, dx_left_s, dy_up_r, dy_up_s;
  logic               serve_left_r, serve_left_s;
  logic [7:0]         speed_r, speed_s, hits_r, hits_s, hits_inc_s;
  logic [SCORE_W-1:0] score_left_r, score_left_s, score_right_r, score_right_s;
  logic [15:0]        serve_cnt_r, serve_cnt_s;
  logic               pulse_r, pulse_s, park_s;

  logic [COORD_W-1:0] paddle_left_s, paddle_right_s;
  logic               move_en_s;
  scoord_t            step_s, nx_raw_s, ny_raw_s, ny_s, pad_y_s;
  logic               dy_wall_s, hit_l_s, hit_r_s;

  // Game tick divider; holds its count while the game is paused.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= TICK_LOAD;
    end else if (game_active) begin
      tick_cnt_r <= (tick_cnt_r == '0) ? TICK_LOAD : tick_cnt_r - TW'(1);
    end
  end

  assign tick_s    = game_active && (tick_cnt_r == '0);
  assign move_en_s = (state_r == ST_SERVE) || (state_r == ST_PLAY);

  pong_paddle_ctrl #(
    .SCREEN_H(SCREEN_H), .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H),
    .PADDLE_SPEED(PADDLE_SPEED), .AI_SPEED(AI_SPEED)
  ) u_paddle_left (
    .clk_pix(clk_pix), .rst(rst), .tick(tick_s), .move_en(move_en_s), .ai(ai_left),
    .btn_up(btn_l_up), .btn_down(btn_l_down), .ball_y(ball_y_r), .paddle_y(paddle_left_s)
  );

  pong_paddle_ctrl #(
    .SCREEN_H(SCREEN_H), .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H),
    .PADDLE_SPEED(PADDLE_SPEED), .AI_SPEED(AI_SPEED)
  ) u_paddle_right (
    .clk_pix(clk_pix), .rst(rst), .tick(tick_s), .move_en(move_en_s), .ai(ai_right),
    .btn_up(btn_r_up), .btn_down(btn_r_down), .ball_y(ball_y_r), .paddle_y(paddle_right_s)
  );

  // Next-state logic: FSM, ball motion with wall clamp, paddle hits taking priority over misses.
  always_comb begin
    state_s       = state_r;
    winner_s      = winner_r;
    ball_x_s      = ball_x_r;
    ball_y_s      = ball_y_r;
    dx_left_s     = dx_left_r;
    dy_up_s       = dy_up_r;
    speed_s       = speed_r;
    hits_s        = hits_r;
    serve_left_s  = serve_left_r;
    score_left_s  = score_left_r;
    score_right_s = score_right_r;
    serve_cnt_s   = serve_cnt_r;
    pulse_s       = 1'b0;
    park_s        = 1'b0;

    step_s   = scoord_t'({4'b0000, speed_r});
    nx_raw_s = dx_left_r ? to_s(ball_x_r) - step_s : to_s(ball_x_r) + step_s;
    ny_raw_s = dy_up_r ? to_s(ball_y_r) - step_s : to_s(ball_y_r) + step_s;
    if (ny_raw_s <= ZERO_S) begin
      ny_s      = ZERO_S;
      dy_wall_s = 1'b0;
    end else if (ny_raw_s >= Y_MAX_S) begin
      ny_s      = Y_MAX_S;
      dy_wall_s = 1'b1;
    end else begin
      ny_s      = ny_raw_s;
      dy_wall_s = dy_up_r;
    end
    hit_l_s = dx_left_r &&
              aabb_hit(nx_raw_s, ny_s, BALL_S, LP_X_S, to_s(paddle_left_s), PAD_W_S, PAD_H_S);
    hit_r_s = !dx_left_r &&
              aabb_hit(nx_raw_s, ny_s, BALL_S, RP_X_S, to_s(paddle_right_s), PAD_W_S, PAD_H_S);
    pad_y_s    = hit_l_s ? to_s(paddle_left_s) : to_s(paddle_right_s);
    hits_inc_s = hits_r + 8'd1;

    if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_SERVE;
            park_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (serve_cnt_r >= SERVE_LAST) begin
            state_s   = ST_PLAY;
            dx_left_s = serve_left_r;
          end else begin
            serve_cnt_s = serve_cnt_r + 16'd1;
          end
        end
        ST_PLAY: begin
          if (hit_l_s || hit_r_s) begin
            ball_x_s  = hit_l_s ? LP_BALL_X : RP_BALL_X;
            ball_y_s  = ny_s[COORD_W-1:0];
            dx_left_s = hit_r_s;
            dy_up_s   = (ny_s + HALF_BALL) < (pad_y_s + HALF_PAD);
            if (hits_inc_s >= HITS_V) begin
              hits_s  = 8'd0;
              speed_s = (speed_r < SPD_MAX_V) ? speed_r + 8'd1 : SPD_MAX_V;
            end else begin
              hits_s = hits_inc_s;
            end
          end else if (nx_raw_s < ZERO_S) begin
            score_right_s = score_right_r + 7'd1;
            serve_left_s  = 1'b1;
            pulse_s       = 1'b1;
            park_s        = 1'b1;
            if (score_right_s >= WIN_V) begin
              state_s  = ST_OVER;
              winner_s = WIN_RIGHT;
            end else begin
              state_s = ST_SERVE;
            end
          end else if (nx_raw_s > X_MAX_S) begin
            score_left_s = score_left_r + 7'd1;
            serve_left_s = 1'b0;
            pulse_s      = 1'b1;
            park_s       = 1'b1;
            if (score_left_s >= WIN_V) begin
              state_s  = ST_OVER;
              winner_s = WIN_LEFT;
            end else begin
              state_s = ST_SERVE;
            end
          end else begin
            ball_x_s = nx_raw_s[COORD_W-1:0];
            ball_y_s = ny_s[COORD_W-1:0];
            dy_up_s  = dy_wall_s;
          end
        end
        ST_OVER: begin
          if (start) begin
            state_s       = ST_SERVE;
            winner_s      = WIN_NONE;
            score_left_s  = 7'd0;
            score_right_s = 7'd0;
            park_s        = 1'b1;
          end else begin
            state_s = ST_OVER;
          end
        end
        default: begin
          state_s = ST_IDLE;
          park_s  = 1'b1;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    ball_x_s    = park_s ? X_CTR : ball_x_s;
    ball_y_s    = park_s ? Y_CTR : ball_y_s;
    dy_up_s     = park_s ? 1'b0 : dy_up_s;
    speed_s     = park_s ? SPD_MIN_V : speed_s;
    hits_s      = park_s ? 8'd0 : hits_s;
    serve_cnt_s = park_s ? 16'd0 : serve_cnt_s;
  end

  // Game state registers; point pulse lasts exactly one clock after the scoring tick.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      winner_r      <= WIN_NONE;
      ball_x_r      <= X_CTR;
      ball_y_r      <= Y_CTR;
      dx_left_r     <= 1'b0;
      dy_up_r       <= 1'b0;
      speed_r       <= SPD_MIN_V;
      hits_r        <= 8'd0;
      serve_left_r  <= 1'b0;
      score_left_r  <= 7'd0;
      score_right_r <= 7'd0;
      serve_cnt_r   <= 16'd0;
      pulse_r       <= 1'b0;
    end else begin
      pulse_r <= pulse_s;
      if (tick_s) begin
        state_r       <= state_s;
        winner_r      <= winner_s;
        ball_x_r      <= ball_x_s;
        ball_y_r      <= ball_y_s;
        dx_left_r     <= dx_left_s;
        dy_up_r       <= dy_up_s;
        speed_r       <= speed_s;
        hits_r        <= hits_s;
        serve_left_r  <= serve_left_s;
        score_left_r  <= score_left_s;
        score_right_r <= score_right_s;
        serve_cnt_r   <= serve_cnt_s;
      end
    end
  end

  assign ball_x         = ball_x_r;
  assign ball_y         = ball_y_r;
  assign paddle_left_y  = paddle_left_s;
  assign paddle_right_y = paddle_right_s;
  assign score_left     = score_left_r;
  assign score_right    = score_right_r;
  assign game_state     = state_r;
  assign winner         = winner_r;
  assign point_pulse    = pulse_r;

endmodule

// File: tb/tb_pong_engine.sv
// Randomized bench for pong_engine against a game-level integer model of the rules.
module tb_pong_engine;

  localparam int TD = 4, STK = 3;
  localparam int W = 480, H = 272, BS = 10, PH = 60, PW = 10, PM = 20;
  localparam int PS = 4, AIS = 3, SMIN = 2, SMAX = 6, HPL = 4, WIN = 11;

  logic clk_pix = 1'b0;
  logic rst = 1'b1;
  logic game_active = 1'b1, start = 1'b0, ai_left = 1'b1, ai_right = 1'b1;
  logic btn_l_up = 1'b1, btn_l_down = 1'b1, btn_r_up = 1'b1, btn_r_down = 1'b1;
  logic [9:0] ball_x, ball_y, paddle_left_y, paddle_right_y;
  logic [6:0] score_left, score_right;
  logic [1:0] game_state, winner;
  logic       point_pulse;

  always #5 clk_pix = ~clk_pix;

  pong_engine #(.TICK_DIV(TD), .SERVE_TICKS(STK)) dut (
    .clk_pix(clk_pix), .rst(rst), .game_active(game_active), .start(start),
    .ai_left(ai_left), .ai_right(ai_right),
    .btn_l_up(btn_l_up), .btn_l_down(btn_l_down), .btn_r_up(btn_r_up), .btn_r_down(btn_r_down),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_left_y(paddle_left_y), .paddle_right_y(paddle_right_y),
    .score_left(score_left), .score_right(score_right), .game_state(game_state),
    .winner(winner), .point_pulse(point_pulse)
  );

  int n_checks = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference game state: 0 idle, 1 serve, 2 play, 3 over.
  int m_state, m_bx, m_by, m_dxl, m_dyu, m_spd, m_hits, m_sleft;
  int m_sl, m_sr, m_win, m_scnt, m_pl, m_pr, m_pulse, m_cnt;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int pad_next(input int py, input logic ai, input logic up_n,
                                  input logic dn_n, input int by);
    int t;
    t = py;
    if (ai) begin
      if (by + BS / 2 < py + PH / 2 - AIS) t = py - AIS;
      else if (by + BS / 2 > py + PH / 2 + AIS) t = py + AIS;
    end else if (!up_n) t = py - PS;
    else if (!dn_n) t = py + PS;
    return clampi(t, 0, H - PH);
  endfunction

  function automatic bit touches(input int bx, input int by, input int px, input int py);
    return (bx < px + PW) && (bx + BS > px) && (by < py + PH) && (by + BS > py);
  endfunction

  task automatic park();
    m_bx = (W - BS) / 2; m_by = (H - BS) / 2; m_dyu = 0;
    m_spd = SMIN; m_hits = 0; m_scnt = 0;
  endtask

  task automatic model_reset();
    m_state = 0; park(); m_pl = (H - PH) / 2; m_pr = (H - PH) / 2;
    m_sl = 0; m_sr = 0; m_win = 0; m_pulse = 0; m_dxl = 0; m_sleft = 0; m_cnt = TD - 1;
  endtask

  task automatic score_point(input bit left_missed);
    m_pulse = 1;
    park();
    if (left_missed) begin
      m_sr++; m_sleft = 1;
      if (m_sr >= WIN) begin m_state = 3; m_win = 2; end else m_state = 1;
    end else begin
      m_sl++; m_sleft = 0;
      if (m_sl >= WIN) begin m_state = 3; m_win = 1; end else m_state = 1;
    end
  endtask

  task automatic model_play();
    int nx, ny, dyn, pad;
    bit hl, hr;
    ny = m_by + (m_dyu != 0 ? -m_spd : m_spd);
    dyn = m_dyu;
    if (ny <= 0) begin ny = 0; dyn = 0; end
    else if (ny >= H - BS) begin ny = H - BS; dyn = 1; end
    nx = m_bx + (m_dxl != 0 ? -m_spd : m_spd);
    hl = (m_dxl != 0) && touches(nx, ny, PM, m_pl);
    hr = (m_dxl == 0) && touches(nx, ny, W - PM - PW, m_pr);
    if (hl || hr) begin
      pad = hl ? m_pl : m_pr;
      m_bx = hl ? PM + PW : W - PM - PW - BS;
      m_by = ny;
      m_dxl = hr ? 1 : 0;
      m_dyu = (ny + BS / 2 < pad + PH / 2) ? 1 : 0;
      m_hits++;
      if (m_hits == HPL) begin m_hits = 0; if (m_spd < SMAX) m_spd++; end
    end else if (nx < 0) score_point(1'b1);
    else if (nx > W - BS) score_point(1'b0);
    else begin m_bx = nx; m_by = ny; m_dyu = dyn; end
  endtask

  task automatic model_tick();
    int npl, npr;
    npl = m_pl; npr = m_pr;
    if (m_state == 1 || m_state == 2) begin
      npl = pad_next(m_pl, ai_left, btn_l_up, btn_l_down, m_by);
      npr = pad_next(m_pr, ai_right, btn_r_up, btn_r_down, m_by);
    end
    case (m_state)
      0: if (start) begin m_state = 1; park(); end
      1: if (m_scnt == STK - 1) begin m_state = 2; m_dxl = m_sleft; end else m_scnt++;
      2: model_play();
      default: if (start) begin m_state = 1; m_sl = 0; m_sr = 0; m_win = 0; park(); end
    endcase
    m_pl = npl; m_pr = npr;
  endtask

  task automatic model_clock();
    m_pulse = 0;
    if (game_active) begin
      if (m_cnt == 0) begin model_tick(); m_cnt = TD - 1; end
      else m_cnt--;
    end
  endtask

  task automatic compare_all();
    check_val("game_state", game_state, m_state);
    check_val("ball_x", ball_x, m_bx);
    check_val("ball_y", ball_y, m_by);
    check_val("paddle_left_y", paddle_left_y, m_pl);
    check_val("paddle_right_y", paddle_right_y, m_pr);
    check_val("score_left", score_left, m_sl);
    check_val("score_right", score_right, m_sr);
    check_val("winner", winner, m_win);
    check_val("point_pulse", point_pulse, m_pulse);
  endtask

  task automatic cycle();
    @(posedge clk_pix);
    if (rst) model_reset(); else model_clock();
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, game_state, 0);
    check_val({tag, "_ball_x"}, ball_x, 235);
    check_val({tag, "_ball_y"}, ball_y, 131);
    check_val({tag, "_pad_l"}, paddle_left_y, 106);
    check_val({tag, "_pad_r"}, paddle_right_y, 106);
    check_val({tag, "_scores"}, score_left + score_right, 0);
    check_val({tag, "_winner"}, winner, 0);
    check_val({tag, "_pulse"}, point_pulse, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Start held: three serve ticks, then the ball heads right at 2 px per tick.
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_state == 2) break;
      cycle();
    end
    check_val("serve_to_play", game_state, 2);
    repeat (TD) cycle();
    check_val("first_move_x", ball_x, 237);
    repeat (TD) cycle();
    check_val("second_move_x", ball_x, 239);
    start = 1'b0;

    // Random play: mixed AI/human sides, random buttons, pauses and restarts.
    for (int i = 0; i < 6000; i++) begin
      if (n_bad > 40) break;
      if (i % 800 == 0) begin
        ai_left  = 1'($urandom_range(0, 1));
        ai_right = 1'($urandom_range(0, 1));
      end
      btn_l_up    = 1'($urandom_range(0, 1));
      btn_l_down  = 1'($urandom_range(0, 1));
      btn_r_up    = 1'($urandom_range(0, 1));
      btn_r_down  = 1'($urandom_range(0, 1));
      game_active = ($urandom_range(0, 9) != 0);
      start       = ($urandom_range(0, 49) == 0);
      cycle();
    end

    // Freeze mid-play for 1000 cycles, then reset mid-play.
    ai_left = 1'b1; ai_right = 1'b1; game_active = 1'b1; start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (m_state == 2) break;
      cycle();
    end
    start = 1'b0;
    check_val("reach_play", game_state, 2);
    game_active = 1'b0;
    repeat (1000) cycle();
    check_val("frozen_state", game_state, 2);
    game_active = 1'b1;
    repeat (2 * TD) cycle();
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("midrst");
    repeat (2) cycle();
    rst = 1'b0;

    // Full match: left paddle parked at the top so points accrue until someone reaches WIN.
    ai_left = 1'b0; btn_l_up = 1'b0; btn_l_down = 1'b1; ai_right = 1'b1; start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_state == 1) break;
      cycle();
    end
    start = 1'b0;
    for (int i = 0; i < 80000; i++) begin
      if (m_state == 3 || n_bad > 40) break;
      cycle();
    end
    check_val("reach_over", game_state, 3);
    check_val("over_winner", winner, (m_sl >= WIN) ? 1 : 2);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_state == 1) break;
      cycle();
    end
    start = 1'b0;
    check_val("restart_state", game_state, 1);
    check_val("restart_score_l", score_left, 0);
    check_val("restart_score_r", score_right, 0);
    check_val("restart_winner", winner, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
